// File: rtl/hex_scan_driver_if.sv
// PIO-side bundle for hex_scan_driver: packed hex value, decimal points, load strobe,
// live blank mask, and the registered segment/anode/frame outputs.
interface hex_scan_driver_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] value_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    load;
    logic [NUM_DIGITS-1:0]   blank_mask;
    logic [7:0]              seg_n;
    logic [NUM_DIGITS-1:0]   an_n;
    logic                    frame_tick;

    modport master (
        output value_in, dp_in, load, blank_mask,
        input  seg_n, an_n, frame_tick
    );

    modport slave (
        input  value_in, dp_in, load, blank_mask,
        output seg_n, an_n, frame_tick
    );
endinterface

// File: rtl/hex_scan_driver.sv
// Time-multiplexed seven-segment driver with frame-boundary double buffering.
// Optional leading-zero blanking is enabled by defining HEX_LZB_EN.
module hex_scan_driver #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int GAP_CYCLES = 64
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    hex_scan_driver_if.slave pio
);
    localparam int MAX_COUNT = (SCAN_DIV > GAP_CYCLES) ? SCAN_DIV : ((GAP_CYCLES > 1) ? GAP_CYCLES : 1);
    localparam int CW        = $clog2(MAX_COUNT) + 1;
    localparam int IW        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CW-1:0] GAP_LAST   = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [CW-1:0] DRIVE_LAST = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_DIGITS - 1);

    typedef enum logic {
        ST_GAP,
        ST_DRIVE
    } state_t;

    localparam state_t RESET_STATE = (GAP_CYCLES == 0) ? ST_DRIVE : ST_GAP;

    state_t                  state_q, state_d;
    logic [IW-1:0]           index_q, index_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [4*NUM_DIGITS-1:0] shadow_val, shadow_val_d;
    logic [NUM_DIGITS-1:0]   shadow_dp, shadow_dp_d;
    logic                    pending, pending_d;
    logic [4*NUM_DIGITS-1:0] disp_val, disp_val_d;
    logic [NUM_DIGITS-1:0]   disp_dp, disp_dp_d;
    logic [7:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    tick_q;
    logic                    wrap;
    logic [NUM_DIGITS-1:0]   lzb;
    logic [3:0]              nibble;

    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] s;
        unique case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q    <= RESET_STATE;
            index_q    <= '0;
            cnt_q      <= '0;
            shadow_val <= '0;
            shadow_dp  <= '0;
            pending    <= 1'b0;
            disp_val   <= '0;
            disp_dp    <= '0;
            seg_q      <= 8'hFF;
            an_q       <= '1;
            tick_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            cnt_q      <= cnt_d;
            shadow_val <= shadow_val_d;
            shadow_dp  <= shadow_dp_d;
            pending    <= pending_d;
            disp_val   <= disp_val_d;
            disp_dp    <= disp_dp_d;
            seg_q      <= seg_d;
            an_q       <= an_d;
            tick_q     <= wrap;
        end
    end

    // Outputs are computed from the next state so they change together with it.
    always_comb begin
        state_d      = state_q;
        index_d      = index_q;
        cnt_d        = cnt_q + CW'(1);
        wrap         = 1'b0;
        shadow_val_d = shadow_val;
        shadow_dp_d  = shadow_dp;
        pending_d    = pending;
        disp_val_d   = disp_val;
        disp_dp_d    = disp_dp;
        seg_d        = 8'hFF;
        an_d         = '1;
        nibble       = '0;
        lzb          = '0;

        case (state_q)
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = ST_DRIVE;
                    cnt_d   = '0;
                end
            end
            default: begin
                if (cnt_q == DRIVE_LAST) begin
                    cnt_d   = '0;
                    state_d = (GAP_CYCLES == 0) ? ST_DRIVE : ST_GAP;
                    if (index_q == LAST_IDX) begin
                        wrap    = 1'b1;
                        index_d = '0;
                    end else begin
                        index_d = index_q + IW'(1);
                    end
                end
            end
        endcase

        if (pio.load) begin
            shadow_val_d = pio.value_in;
            shadow_dp_d  = pio.dp_in;
            pending_d    = 1'b1;
        end

        // A load landing on the wrap edge bypasses the shadow entirely.
        if (wrap) begin
            if (pio.load) begin
                disp_val_d = pio.value_in;
                disp_dp_d  = pio.dp_in;
                pending_d  = 1'b0;
            end else if (pending) begin
                disp_val_d = shadow_val;
                disp_dp_d  = shadow_dp;
                pending_d  = 1'b0;
            end
        end

`ifdef HEX_LZB_EN
        begin
            logic run;
            run = 1'b1;
            for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
                run    = run && (disp_val_d[4*i +: 4] == 4'h0) && !disp_dp_d[i];
                lzb[i] = (i != 0) && run;
            end
        end
`else
        lzb = '0;
`endif

        nibble = disp_val_d[4*index_d +: 4];
        if (state_d == ST_DRIVE && !pio.blank_mask[index_d] && !lzb[index_d]) begin
            an_d[index_d] = 1'b0;
            seg_d         = {~disp_dp_d[index_d], decode(nibble)};
        end
    end

    assign pio.seg_n      = seg_q;
    assign pio.an_n       = an_q;
    assign pio.frame_tick = tick_q;

endmodule

// File: tb/tb_hex_scan_driver.sv
// Directed bench for hex_scan_driver (4 digits, 4-cycle dwell, 2-cycle gap, 24-cycle frame).
// Expected values for leading-zero blanking are selected when HEX_LZB_EN is defined.
module tb_hex_scan_driver;
    localparam int ND  = 4;
    localparam int SD  = 4;
    localparam int GC  = 2;
    localparam int SLOT = SD + GC;

    logic clk;
    logic rst_n;

    hex_scan_driver_if #(.NUM_DIGITS(ND)) bus ();

    hex_scan_driver #(
        .NUM_DIGITS(ND),
        .SCAN_DIV  (SD),
        .GAP_CYCLES(GC)
    ) dut (
        .clk_clk      (clk),
        .reset_reset_n(rst_n),
        .pio          (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors_applied = 0;
    int miscompares     = 0;

    typedef struct {
        logic [15:0]     value;
        logic [3:0]      dp;
        logic [3:0]      blank;
        logic [3:0][7:0] exp_seg;
        logic [3:0][7:0] exp_lzb;
    } vec_t;

    vec_t vecs [8];

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        vectors_applied++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] value, input logic [3:0] dp);
        bus.value_in = value;
        bus.dp_in    = dp;
        bus.load     = 1'b1;
        @(negedge clk);
        bus.load     = 1'b0;
    endtask

    // Returns at the negedge inside the cycle where frame_tick is high.
    task automatic wait_frame(output int waited);
        logic found;
        found  = 1'b0;
        waited = 0;
        for (int k = 0; k < 60 && !found; k++) begin
            @(negedge clk);
            waited++;
            if (bus.frame_tick === 1'b1) found = 1'b1;
        end
        if (!found) checkOutput("frame_tick_timeout", 16'd0, 16'd1);
    endtask

    function automatic logic [3:0] an_for(input int d, input logic [7:0] seg);
        logic [3:0] a;
        a = 4'hF;
        if (seg != 8'hFF) a[d] = 1'b0;
        return a;
    endfunction

    initial begin
        int         n;
        int         off;
        logic [7:0] e;
        logic       saw88;
        logic [7:0] d1_seg;

        vecs[0] = '{16'h1234, 4'h0, 4'h0, {8'hF9, 8'hA4, 8'hB0, 8'h99}, {8'hF9, 8'hA4, 8'hB0, 8'h99}};
        vecs[1] = '{16'h00F0, 4'h0, 4'h0, {8'hC0, 8'hC0, 8'h8E, 8'hC0}, {8'hFF, 8'hFF, 8'h8E, 8'hC0}};
        vecs[2] = '{16'hABCD, 4'h5, 4'h0, {8'h88, 8'h03, 8'hC6, 8'h21}, {8'h88, 8'h03, 8'hC6, 8'h21}};
        vecs[3] = '{16'h89EF, 4'h0, 4'h2, {8'h80, 8'h90, 8'hFF, 8'h8E}, {8'h80, 8'h90, 8'hFF, 8'h8E}};
        vecs[4] = '{16'h0007, 4'h0, 4'h0, {8'hC0, 8'hC0, 8'hC0, 8'hF8}, {8'hFF, 8'hFF, 8'hFF, 8'hF8}};
        vecs[5] = '{16'h0000, 4'h4, 4'h0, {8'hC0, 8'h40, 8'hC0, 8'hC0}, {8'hFF, 8'h40, 8'hC0, 8'hC0}};
        vecs[6] = '{16'h0000, 4'h0, 4'h0, {8'hC0, 8'hC0, 8'hC0, 8'hC0}, {8'hFF, 8'hFF, 8'hFF, 8'hC0}};
        vecs[7] = '{16'h5670, 4'h0, 4'h9, {8'hFF, 8'h82, 8'hF8, 8'hFF}, {8'hFF, 8'h82, 8'hF8, 8'hFF}};

        rst_n          = 1'b0;
        bus.value_in   = '0;
        bus.dp_in      = '0;
        bus.load       = 1'b0;
        bus.blank_mask = '0;

        $display("[TB] reset and first frame");
        repeat (3) @(negedge clk);
        checkOutput("reset_an_n", 16'(bus.an_n), 16'h000F);
        checkOutput("reset_seg_n", 16'(bus.seg_n), 16'h00FF);
        checkOutput("reset_frame_tick", 16'(bus.frame_tick), 16'h0000);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("gap_cycle1_an_n", 16'(bus.an_n), 16'h000F);
        @(negedge clk);
        checkOutput("cycle2_seg_n", 16'(bus.seg_n), 16'h00C0);
        checkOutput("cycle2_an_n", 16'(bus.an_n), 16'h000E);
        applyStimulus(16'h1234, 4'h0);
        repeat (5) @(negedge clk);
`ifdef HEX_LZB_EN
        checkOutput("frame0_d1_seg_n", 16'(bus.seg_n), 16'h00FF);
        checkOutput("frame0_d1_an_n", 16'(bus.an_n), 16'h000F);
`else
        checkOutput("frame0_d1_seg_n", 16'(bus.seg_n), 16'h00C0);
        checkOutput("frame0_d1_an_n", 16'(bus.an_n), 16'h000D);
`endif
        wait_frame(n);
        checkOutput("first_tick_cycle", 16'(8 + n), 16'd24);
        @(negedge clk);
        checkOutput("tick_one_cycle", 16'(bus.frame_tick), 16'h0000);
        repeat (2) @(negedge clk);
        checkOutput("frame1_d0_seg_n", 16'(bus.seg_n), 16'h0099);
        checkOutput("frame1_d0_an_n", 16'(bus.an_n), 16'h000E);
        repeat (18) @(negedge clk);
        checkOutput("frame1_d3_seg_n", 16'(bus.seg_n), 16'h00F9);
        checkOutput("frame1_d3_an_n", 16'(bus.an_n), 16'h0007);

        $display("[TB] table vectors");
        for (int i = 0; i < 8; i++) begin
            wait_frame(n);
            bus.blank_mask = vecs[i].blank;
            applyStimulus(vecs[i].value, vecs[i].dp);
            wait_frame(n);
            off = 0;
            for (int d = 0; d < ND; d++) begin
                while (off < SLOT * d + GC + 1) begin
                    @(negedge clk);
                    off++;
                end
`ifdef HEX_LZB_EN
                e = vecs[i].exp_lzb[d];
`else
                e = vecs[i].exp_seg[d];
`endif
                checkOutput($sformatf("vec%0d_d%0d_seg_n", i, d), 16'(bus.seg_n), 16'(e));
                checkOutput($sformatf("vec%0d_d%0d_an_n", i, d), 16'(bus.an_n), 16'(an_for(d, e)));
            end
        end
        bus.blank_mask = '0;

        $display("[TB] two loads in one frame, last wins");
        wait_frame(n);
        applyStimulus(16'hAAAA, 4'h0);
        repeat (4) @(negedge clk);
        applyStimulus(16'h00F0, 4'h0);
        wait_frame(n);
        saw88  = 1'b0;
        d1_seg = 8'h00;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            if (bus.seg_n == 8'h88) saw88 = 1'b1;
            if (k == 9) d1_seg = bus.seg_n;
        end
        checkOutput("last_wins_d1_seg_n", 16'(d1_seg), 16'h008E);
        checkOutput("stale_AAAA_seen", 16'(saw88), 16'h0000);

        $display("[TB] load on the wrap edge");
        wait_frame(n);
        repeat (5) @(negedge clk);
        applyStimulus(16'h1111, 4'h0);
        repeat (17) @(negedge clk);
        bus.value_in = 16'h5555;
        bus.dp_in    = 4'h0;
        bus.load     = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
        checkOutput("wrap_load_frame_tick", 16'(bus.frame_tick), 16'h0001);
        off = 0;
        for (int d = 0; d < ND; d++) begin
            while (off < SLOT * d + GC + 1) begin
                @(negedge clk);
                off++;
            end
            checkOutput($sformatf("bypass_d%0d_seg_n", d), 16'(bus.seg_n), 16'h0092);
        end
        wait_frame(n);
        repeat (SLOT * 2 + GC + 1) @(negedge clk);
        checkOutput("bypass_next_frame_d2_seg_n", 16'(bus.seg_n), 16'h0092);

        $display("[TB] asynchronous reset during digit 2");
        wait_frame(n);
        repeat (SLOT * 2 + GC + 1) @(negedge clk);
        checkOutput("pre_reset_d2_an_n", 16'(bus.an_n), 16'h000B);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_an_n", 16'(bus.an_n), 16'h000F);
        checkOutput("async_reset_seg_n", 16'(bus.seg_n), 16'h00FF);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("restart_d0_seg_n", 16'(bus.seg_n), 16'h00C0);
        checkOutput("restart_d0_an_n", 16'(bus.an_n), 16'h000E);
        wait_frame(n);
        checkOutput("restart_tick_cycle", 16'(2 + n), 16'd24);

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
